// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: state encoding and nibble width.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  // 2'd3 is unused; the sequencer treats it as IDLE on the next edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladd4.sv
// 4-bit ripple-carry adder: one nibble of the serial datapath.
module fulladd4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  // Ripple the carry bit by bit through four full-adder cells.
  always_comb begin
    carry[0] = cin;
    sum      = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    cout = carry[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single fulladd4,
// with the carry registered between passes.
//
// Handshake: start is sampled only in IDLE; the accepting edge captures a, b
// and cin. busy is high while nibbles are being added, done pulses for one
// cycle when sum/cout/ovf are final. sum/cout/ovf hold until the next op
// completes; sum is written nibble by nibble, so it is only meaningful from
// done onward.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] fa_a, fa_b, fa_sum;
  logic                fa_cout;
  logic                carry_into_msb;

  // Select the current nibble of each captured operand.
  always_comb begin
    fa_a = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
    fa_b = b_q[idx_q * NIBBLE_W +: NIBBLE_W];
  end

  fulladd4 u_fulladd4 (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Sequencer next-state: capture in IDLE, one nibble per edge in RUN, pulse in DONE.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    carry_d        = carry_q;
    a_d            = a_q;
    b_d            = b_q;
    sum_d          = sum_q;
    cout_d         = cout_q;
    ovf_d          = ovf_q;
    // The carry into the top bit is recovered from the top sum bit.
    carry_into_msb = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ fa_sum[NIBBLE_W-1];
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q * NIBBLE_W +: NIBBLE_W] = fa_sum;
        carry_d = fa_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = fa_cout;
          ovf_d   = carry_into_msb ^ fa_cout;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

endmodule
